// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports plus the shared data-memory port.
//   req0/we0/addr0/wdata0  -> port 0 request (CPU load/store path)
//   gnt0/rvalid0/rdata0    <- port 0 grant pulse, read-valid pulse, read data
//   req1..rdata1           same for port 1 (secondary master)
//   mem_access_addr, mem_write_data, mem_write_en, mem_read -> memory
//   mem_read_data          <- memory (combinational read)
//   busy                   <- arbiter not idle
// slave: arbiter side. master: requester/memory environment side.
interface data_mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req0, we0, gnt0, rvalid0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic              mem_write_en, mem_read;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_read_data,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_access_addr, mem_write_data, mem_write_en, mem_read, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_read_data,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_access_addr, mem_write_data, mem_write_en, mem_read, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between two masters.
// One access every three cycles: IDLE (sample/arbitrate) -> ACCESS (gnt and
// memory strobes driven) -> RESP (rvalid for reads).
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : requester ports and memory port (see data_mem_arbiter_if)
module data_mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            r_state;
  logic              r_ptr;      // last-granted port
  logic              r_win;      // port owning the access in flight
  logic              r_we;
  logic              r_gnt0, r_gnt1, r_rvalid0, r_rvalid1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_wen, r_mem_rd;

  logic              w_any, w_pick1, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // On a tie the port that was not granted last wins.
  always_comb begin
    w_any   = bus.req0 | bus.req1;
    w_pick1 = bus.req1 & (~bus.req0 | ~r_ptr);
    w_we    = w_pick1 ? bus.we1    : bus.we0;
    w_addr  = w_pick1 ? bus.addr1  : bus.addr0;
    w_wdata = w_pick1 ? bus.wdata1 : bus.wdata0;
  end

  // Memory strobes are the registered request latches themselves, so the
  // asynchronous reset drops mem_write_en before an aborted write can land.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b1;
      r_win       <= 1'b0;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_rd    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= ACCESS;
            r_ptr       <= w_pick1;
            r_win       <= w_pick1;
            r_we        <= w_we;
            r_gnt0      <= ~w_pick1;
            r_gnt1      <= w_pick1;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_we ? w_wdata : '0;
            r_mem_wen   <= w_we;
            r_mem_rd    <= ~w_we;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_gnt0      <= 1'b0;
          r_gnt1      <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_mem_wen   <= 1'b0;
          r_mem_rd    <= 1'b0;
          if (!r_we) begin
            if (r_win) begin
              r_rdata1  <= bus.mem_read_data;
              r_rvalid1 <= 1'b1;
            end else begin
              r_rdata0  <= bus.mem_read_data;
              r_rvalid0 <= 1'b1;
            end
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_rvalid0 <= 1'b0;
          r_rvalid1 <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0            = r_gnt0;
  assign bus.gnt1            = r_gnt1;
  assign bus.rvalid0         = r_rvalid0;
  assign bus.rvalid1         = r_rvalid1;
  assign bus.rdata0          = r_rdata0;
  assign bus.rdata1          = r_rdata1;
  assign bus.mem_access_addr = r_mem_addr;
  assign bus.mem_write_data  = r_mem_wdata;
  assign bus.mem_write_en    = r_mem_wen;
  assign bus.mem_read        = r_mem_rd;
  assign bus.busy            = (r_state != IDLE);

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 16-bit data memory between the CPU load/store path (port 0) and a secondary master (port 1), e.g. a debug or loader engine.
- Latches one request per slot, drives the memory's shared address, write-data, write-enable and read-strobe inputs for exactly one cycle, and returns registered read data.
- Arbitration is round-robin.
- Sits between the datapath/secondary master and the data memory instance in the processor top level.

Parameters:
- DATA_W, 16, width of data words (matches memory column width).
- ADDR_W, 16, width of address passed through to the memory (the memory decodes the low bits itself).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req0  input  1  port 0 request; held high until gnt0 is seen
- we0  input  1  port 0 write (1) / read (0); valid with req0
- addr0  input  ADDR_W  port 0 address
- wdata0  input  DATA_W  port 0 write data
- gnt0  output  1  one-cycle pulse: port 0 request accepted and being executed
- rvalid0  output  1  one-cycle pulse: rdata0 valid (reads only)
- rdata0  output  DATA_W  port 0 read data, held until next port 0 read completes
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_access_addr  output  ADDR_W  to memory, shared address
- mem_write_data  output  DATA_W  to memory
- mem_write_en  output  1  to memory
- mem_read  output  1  to memory
- mem_read_data  input  DATA_W  from memory (combinational read)
- busy  output  1  high while state is not IDLE

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0; latched request cleared; last-granted pointer = 1, so port 0 wins the first tie.
- State machine:
  - IDLE -> ACCESS when any req is sampled high at a rising edge.
  - ACCESS -> RESP always after one cycle.
  - RESP -> IDLE always after one cycle.
  - No request is sampled in ACCESS or RESP.
- Arbitration at the IDLE edge:
  - Only one req high: that port wins.
  - Both high: the port not equal to the last-granted pointer wins; pointer updates to the winner.
  - At the same edge, latch the winner's we/addr/wdata and the winner id.
- ACCESS cycle (registered outputs):
  - gnt of winner = 1.
  - mem_access_addr = latched addr.
  - Write: mem_write_en=1, mem_write_data = latched wdata, mem_read=0. The memory writes at the edge ending ACCESS.
  - Read: mem_read=1, mem_write_en=0. mem_read_data is captured into the winner's rdata at the edge ending ACCESS.
- RESP cycle:
  - All mem_* outputs = 0; gnt = 0.
  - For a read, rvalid of the winner = 1 with rdata stable.
  - For a write, no rvalid.
- Latency: request sampled at edge E → gnt high cycle E+1 → read data valid cycle E+2. Throughput is one access per 3 cycles.
- Requester handshake rule: deassert req, or present the next request, during or after the gnt cycle. A req still high at the next IDLE edge is a new request.
- In IDLE all mem_* outputs = 0; gnt0, gnt1, rvalid0 and rvalid1 are never high simultaneously.
- rdata of the non-winning port is unchanged.
- Reset asserted during ACCESS:
  - mem_write_en drops asynchronously, so the aborted write must not occur.
  - No gnt/rvalid pulse is emitted after reset release.
- Requests changing while state is not IDLE have no effect on the access in flight.
- Addresses and data pass through unmodified; no width conversion.

Test Plan:
- Reset then port 0 write: req0=1, we0=1, addr0=3, wdata0=16'hA5A5 → gnt0 pulse 1 cycle later with mem_write_en=1, mem_access_addr=3; memory word 3 = 16'hA5A5; no rvalid0.
- Port 1 read of addr 3 after the above → gnt1 at E+1 with mem_read=1, rvalid1 at E+2 with rdata1=16'hA5A5; rdata0 unchanged.
- Both req0 and req1 held high continuously from reset → grant order 0,1,0,1; one gnt every 3 cycles; never two gnts or two rvalids in one cycle.
- req1 held for 2 cycles while port 0 is in ACCESS → port 1 served at the next IDLE edge; busy=1 for exactly 2 cycles per access.
- Reset asserted mid-ACCESS of a write wdata0=16'h1234 to addr 5 → all outputs 0 immediately, state IDLE; memory word 5 retains its previous value.
- Read from port 0 while req1 toggles → port 0 access completes unaltered; gnt1 appears only after RESP.
